// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer controllers: depth/width helpers and Gray conversions.
package fifo_pkg;

    function automatic int unsigned fifo_depth(input int unsigned addr);
        return 32'd1 << addr;
    endfunction

    // Pointers and levels carry one extra bit so that full and empty can be told apart.
    function automatic int unsigned lvl_width(input int unsigned addr);
        return addr + 32'd1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin = '0;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter; shared by the write- and read-side pointer controllers.
module fifo_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits from the MSB down to itself.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-domain pointer, full/almost-full and fill-level controller of the async FIFO.
// Optional sticky overflow flag is built when FIFO_WPTR_OVF_EN is defined.
module fifo_wptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR   = 4,
    parameter int AF_RST = (1 << ADDR) - 2
) (
    input  logic            i_wclk,
    input  logic            i_wrst,
    input  logic            i_winc,
    input  logic [ADDR:0]   i_r2w,
    input  logic [ADDR:0]   i_afull_thr,
    input  logic            i_ovf_clr,
    output logic            o_wen,
    output logic [ADDR-1:0] o_waddr,
    output logic [ADDR:0]   o_wptr_gray,
    output logic            o_wfull,
    output logic            o_walmost_full,
    output logic [ADDR:0]   o_wlevel,
    output logic            o_wovf
);

    localparam int PW = int'(lvl_width(ADDR));

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] wgraynext;
    logic [PW-1:0] rbin;
    logic [PW-1:0] lvl_next;
    logic [31:0]   gray32;
    logic          wen;
    logic          wfull_val;

    logic [31-PW:0] unused_gray_hi;
    logic [PW-1:0]  unused_af_rst;

    // Writes are dropped while full, and no RAM strobe escapes while reset is held.
    assign wen      = i_winc & ~o_wfull & ~i_wrst;
    assign wbinnext = wbin + {{ADDR{1'b0}}, wen};

    assign gray32         = bin2gray(32'(wbinnext));
    assign wgraynext      = gray32[PW-1:0];
    assign unused_gray_hi = gray32[31:PW];
    assign unused_af_rst  = PW'(AF_RST);

    fifo_gray2bin #(
        .W(PW)
    ) u_r2w_g2b (
        .gray(i_r2w),
        .bin (rbin)
    );

    // Full when the next write pointer is exactly one lap ahead of the synchronised read pointer.
    assign wfull_val = (wgraynext == {~i_r2w[ADDR:ADDR-1], i_r2w[ADDR-2:0]});
    assign lvl_next  = wbinnext - rbin;

    always_ff @(posedge i_wclk or posedge i_wrst) begin
        if (i_wrst) begin
            wbin           <= '0;
            o_wptr_gray    <= '0;
            o_wfull        <= 1'b0;
            o_walmost_full <= 1'b0;
            o_wlevel       <= '0;
        end else begin
            wbin           <= wbinnext;
            o_wptr_gray    <= wgraynext;
            o_wfull        <= wfull_val;
            o_walmost_full <= (lvl_next >= i_afull_thr);
            o_wlevel       <= lvl_next;
        end
    end

    assign o_wen   = wen;
    assign o_waddr = wbin[ADDR-1:0];

`ifdef FIFO_WPTR_OVF_EN
    // A new overflow in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_wclk or posedge i_wrst) begin
        if (i_wrst) begin
            o_wovf <= 1'b0;
        end else if (i_winc & o_wfull) begin
            o_wovf <= 1'b1;
        end else if (i_ovf_clr) begin
            o_wovf <= 1'b0;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = i_ovf_clr;
    assign o_wovf         = 1'b0;
`endif

endmodule

// File: doc/fifo_wptr_ctrl.md
Name: fifo_wptr_ctrl

Overview:
Write-domain pointer/flag controller for the async FIFO, successor to the basic write-pointer block. Generalised depth (ADDR), adds registered fill level, programmable almost-full, memory write strobe, and optional sticky overflow error. Sits in the write clock domain between the producer, the dual-port RAM write port, and the read-to-write pointer synchroniser.

Parameters:
ADDR, 4, RAM address width; depth = 2**ADDR; pointers ADDR+1 bits; legal ADDR >= 2
AF_RST, 2**ADDR-2, reset/default almost-full threshold used when i_afull_thr is tied to it by integrator (documentation value only)

Ports:
i_wclk  in  1  write-domain clock
i_wrst  in  1  reset; one clock; reset is asynchronous and active-high
i_winc  in  1  producer write request
i_r2w  in  ADDR+1  synchronised read pointer, Gray code
i_afull_thr  in  ADDR+1  almost-full threshold, 0..2**ADDR, quasi-static
i_ovf_clr  in  1  clears sticky overflow (feature only)
o_wen  out  1  RAM write enable = i_winc & ~o_wfull (combinational)
o_waddr  out  ADDR  RAM write address = binary pointer [ADDR-1:0]
o_wptr_gray  out  ADDR+1  registered Gray write pointer to synchroniser
o_wfull  out  1  registered full
o_walmost_full  out  1  registered almost-full
o_wlevel  out  ADDR+1  registered occupancy as seen by write side, 0..2**ADDR
o_wovf  out  1  sticky overflow (feature only; else tied 0)

Behaviour:
- Reset (i_wrst high, async): binary ptr, o_wptr_gray, o_wlevel = 0; o_wfull, o_walmost_full, o_wovf = 0. Release synchronous to i_wclk edge by integrator.
- wbinnext = wbin + o_wen, modulo 2**(ADDR+1); natural wrap 2**(ADDR+1)-1 -> 0; o_waddr wraps 2**ADDR-1 -> 0.
- wgraynext = wbinnext ^ (wbinnext >> 1); registered to o_wptr_gray each edge.
- rbin = Gray-to-binary of i_r2w (combinational, MSB-down XOR chain).
- Full: wfull_val = (wgraynext == {~i_r2w[ADDR:ADDR-1], i_r2w[ADDR-2:0]}); registered. Full asserts on the same edge that commits the 2**ADDR-th unread write (zero-cycle lag).
- Full deassert: one i_wclk edge after i_r2w shows read progress (pessimistic by sync latency; never optimistic).
- Write while full: dropped; o_wen = 0, pointers unchanged.
- Level: lvl_next = wbinnext - rbin, ADDR+1 bits, unsigned modulo; registered to o_wlevel. Must equal 2**ADDR exactly when wfull_val.
- Almost-full: registered (lvl_next >= i_afull_thr). Threshold 0 -> always asserted after reset release; threshold 2**ADDR -> equals full.
- Simultaneous write and i_r2w change: both applied in the same lvl_next evaluation.
- Reset mid-operation: all state cleared immediately regardless of i_winc; no RAM write strobe while i_wrst high (o_wen forced 0).

Optional Feature:
FIFO_WPTR_OVF_EN: when defined, o_wovf set on any edge where i_winc & o_wfull; held until an edge with i_ovf_clr high and no new overflow; set wins over clear in the same cycle. When undefined, o_wovf tied 0, i_ovf_clr ignored, no flop inferred.

Decomposition:
- Package fifo_pkg: function gray2bin/bin2gray (parametrised width), localparam DEPTH = 2**ADDR helper, level type width ADDR+1.
- One sub-module natural: fifo_gray2bin (combinational, width parameter), reused by read-side controller.

Test Plan:
- ADDR=4, i_r2w=0, 16 consecutive writes -> o_wfull=1 after 16th edge, o_wlevel=16, o_waddr=0, o_wptr_gray=5'b11000.
- Full, i_winc=1 for 3 cycles -> o_wen=0, pointers frozen, o_wovf=1 (feature on) / 0 (off); i_ovf_clr pulse -> o_wovf=0 next edge; clr with concurrent overflow -> stays 1.
- Full, i_r2w steps to Gray(4)=5'b00110 -> o_wfull=0 one edge later, o_wlevel=12.
- i_afull_thr=12, write from empty -> o_walmost_full rises on edge committing 12th write, falls when level drops to 11.
- Continuous write/read streaming 100 entries -> binary pointer wraps 31->0, o_wlevel never >16, no false full, Gray pointer changes one bit per step.
- Assert i_wrst mid-burst (level 9) -> all outputs 0 asynchronously; after release, first write goes to o_waddr=0.
